sw_pe_dispatcher: RTL

- Scheduler between the 4-bit-to-wide data arranger and a bank of PE_NUM Smith-Waterman scoring PEs.
- Tells the arranger when a PE is free, captures each arranged word once, and issues it to one idle PE.
- Selects PEs round-robin, tracks per-PE busy state from done pulses, and keeps a dispatch count and an error flag.

---
 rtl/sw_pe_dispatcher_if.sv | 33 +++
 rtl/sw_pe_dispatcher.sv | 118 +++++++++++
 2 files changed

// File: rtl/sw_pe_dispatcher_if.sv
// Purpose: groups the arranger-side and PE-side signals of the Smith-Waterman PE dispatcher.
// Ports: arrange_ready/data_in/pe_done come from the arranger and the PEs; pe_empty, pe_load,
//        pe_data, busy, all_idle, dispatch_cnt and err_done are driven by the dispatcher.
// Modports: master = arranger/PE side (drives the inputs), slave = dispatcher.
interface sw_pe_dispatcher_if #(
  parameter int DATA_WIDTH = 252,
  parameter int PE_NUM     = 4
);
  // arranger -> dispatcher
  logic                  arrange_ready;
  logic [DATA_WIDTH-1:0] data_in;
  // dispatcher -> arranger
  logic                  pe_empty;
  // dispatcher <-> PE bank
  logic [PE_NUM-1:0]     pe_load;
  logic [DATA_WIDTH-1:0] pe_data;
  logic [PE_NUM-1:0]     pe_done;
  // status
  logic [PE_NUM-1:0]     busy;
  logic                  all_idle;
  logic [15:0]           dispatch_cnt;
  logic                  err_done;

  modport master (
    output arrange_ready, data_in, pe_done,
    input  pe_empty, pe_load, pe_data, busy, all_idle, dispatch_cnt, err_done
  );

  modport slave (
    input  arrange_ready, data_in, pe_done,
    output pe_empty, pe_load, pe_data, busy, all_idle, dispatch_cnt, err_done
  );
endinterface

// File: rtl/sw_pe_dispatcher.sv
// Purpose: captures each arranged word once and issues it to one idle scoring PE, round-robin.
// Latency: accept sampled at edge N, one-hot pe_load high in the cycle after edge N+1.
// Backpressure: pe_empty (combinational) is low while a word is held or every PE is busy.
// Ports: clk, rst (async, active-low), bus (slave modport of sw_pe_dispatcher_if).
module sw_pe_dispatcher #(
  parameter int DATA_WIDTH = 252,
  parameter int PE_NUM     = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sw_pe_dispatcher_if.slave    bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                r_state;
  logic [PE_NUM-1:0]     r_busy;
  logic [PTR_WIDTH-1:0]  r_rr_ptr;
  logic [PE_NUM-1:0]     r_pe_load;
  logic [DATA_WIDTH-1:0] r_pe_data;
  logic [15:0]           r_dispatch_cnt;
  logic                  r_err_done;
  logic                  r_ready_q;
  logic [DATA_WIDTH-1:0] r_hold;

  logic                  w_accept;
  logic                  w_pe_empty;
  logic [PE_NUM-1:0]     w_busy_clr;
  logic                  w_done_err;
  logic                  w_sel_vld;
  logic [PTR_WIDTH-1:0]  w_sel;
  logic [PTR_WIDTH:0]    w_idx;
  logic [PE_NUM-1:0]     w_sel_onehot;
  logic [PTR_WIDTH-1:0]  w_rr_next;

  // The arranger holds ready high for up to two cycles per word, so only the
  // rising edge counts as a new word.
  assign w_accept   = bus.arrange_ready & ~r_ready_q;
  assign w_pe_empty = (r_state == ST_IDLE) && (r_busy != {PE_NUM{1'b1}});

  // Done pulses clear busy; a done for an idle PE is an error and leaves busy at 0.
  assign w_busy_clr = r_busy & ~bus.pe_done;
  assign w_done_err = |(bus.pe_done & ~r_busy);

  // Round-robin search starting at r_rr_ptr. The index is formed one bit wider
  // and reduced modulo PE_NUM so non-power-of-2 PE counts wrap correctly.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_idx     = '0;
    for (int k = 0; k < PE_NUM; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_WIDTH+1)'(k);
      if (w_idx >= (PTR_WIDTH+1)'(PE_NUM)) begin
        w_idx = w_idx - (PTR_WIDTH+1)'(PE_NUM);
      end
      if (!w_sel_vld && !r_busy[w_idx[PTR_WIDTH-1:0]]) begin
        w_sel_vld = 1'b1;
        w_sel     = w_idx[PTR_WIDTH-1:0];
      end
    end
  end

  assign w_sel_onehot = PE_NUM'(1) << w_sel;
  assign w_rr_next    = (w_sel == PTR_WIDTH'(PE_NUM - 1)) ? '0 : w_sel + PTR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_busy         <= '0;
      r_rr_ptr       <= '0;
      r_pe_load      <= '0;
      r_pe_data      <= '0;
      r_dispatch_cnt <= '0;
      r_err_done     <= 1'b0;
      r_ready_q      <= 1'b0;
      r_hold         <= '0;
    end else begin
      r_ready_q  <= bus.arrange_ready;
      r_pe_load  <= '0;
      r_busy     <= w_busy_clr;
      r_err_done <= r_err_done | w_done_err;
      case (r_state)
        ST_IDLE: begin
          // An accept while no PE is free is dropped, not remembered.
          if (w_accept && w_pe_empty) begin
            r_hold  <= bus.data_in;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // arrange_ready is ignored here; if nothing is free, retry next cycle.
          if (w_sel_vld) begin
            r_pe_load      <= w_sel_onehot;
            r_pe_data      <= r_hold;
            r_busy         <= w_busy_clr | w_sel_onehot;
            r_rr_ptr       <= w_rr_next;
            r_dispatch_cnt <= r_dispatch_cnt + 16'd1;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pe_empty     = w_pe_empty;
  assign bus.pe_load      = r_pe_load;
  assign bus.pe_data      = r_pe_data;
  assign bus.busy         = r_busy;
  assign bus.all_idle     = (r_busy == '0) && (r_state == ST_IDLE);
  assign bus.dispatch_cnt = r_dispatch_cnt;
  assign bus.err_done     = r_err_done;

endmodule
